// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter
// Single-master AXI-style bus interface that sits behind the cache layer.
// The read channel is shared between the instruction side and the data side,
// with the data side taking priority. The write channel serves the data side
// only. The read and write FSMs run concurrently. A data read that targets the
// line of an in-flight write is held back until that write completes.
//
// Ports:
//   clk, resetn                      clock and synchronous active-low reset
//   inst_rd_*  / inst_ret_*          icache read request and returned beats
//   data_rd_*  / data_ret_*          data-side read request and returned beats
//   data_wr_*                        data-side write request (word or line)
//   ar*, r*, aw*, w*, b*             AXI master channels
module axi_bus_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ID_INST    = 0,
    parameter int ID_DATA    = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    // instruction-side read
    input  logic                      inst_rd_req,
    input  logic [2:0]                inst_rd_type,
    input  logic [31:0]               inst_rd_addr,
    output logic                      inst_rd_rdy,
    output logic                      inst_ret_valid,
    output logic                      inst_ret_last,
    output logic [31:0]               inst_ret_data,
    // data-side read
    input  logic                      data_rd_req,
    input  logic [2:0]                data_rd_type,
    input  logic [31:0]               data_rd_addr,
    output logic                      data_rd_rdy,
    output logic                      data_ret_valid,
    output logic                      data_ret_last,
    output logic [31:0]               data_ret_data,
    // data-side write
    input  logic                      data_wr_req,
    input  logic [2:0]                data_wr_type,
    input  logic [31:0]               data_wr_addr,
    input  logic [3:0]                data_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]  data_wr_data,
    output logic                      data_wr_rdy,
    // AXI read address
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic                      arvalid,
    input  logic                      arready,
    // AXI read data
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    // AXI write address
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic                      awvalid,
    input  logic                      awready,
    // AXI write data
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    // AXI write response
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int         CNT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);
    localparam logic [3:0] ID_I     = 4'(ID_INST);
    localparam logic [3:0] ID_D     = 4'(ID_DATA);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} w_state_t;

    r_state_t           r_state;
    logic [31:0]        rd_addr_q;
    logic               rd_line_q;
    logic               rd_owner_q;      // 1 = data side, 0 = instruction side

    w_state_t           w_state;
    logic [31:0]        wr_addr_q;
    logic               wr_line_q;
    logic [3:0]         wr_strb_q;
    logic [31:0]        wr_words [LINE_WORDS];
    logic [CNT_W-1:0]   cnt;

    logic               wr_accept;
    logic               data_hold;
    logic               data_grant;
    logic               inst_grant;
    logic               beat_match;
    logic               wlast_int;

    // A data read must not overtake a write to the same line. The second term
    // covers a write that is only being accepted this cycle, before its address
    // has been captured.
    assign wr_accept  = resetn && (w_state == W_IDLE) && data_wr_req;
    assign data_hold  = ((w_state != W_IDLE) && (data_rd_addr[31:4] == wr_addr_q[31:4])) ||
                        (wr_accept && (data_rd_addr[31:4] == data_wr_addr[31:4]));
    assign data_grant = resetn && (r_state == R_IDLE) && data_rd_req && !data_hold;
    assign inst_grant = resetn && (r_state == R_IDLE) && inst_rd_req && !data_grant;

    assign inst_rd_rdy = inst_grant;
    assign data_rd_rdy = data_grant;
    assign data_wr_rdy = wr_accept;

    // Read address / data channel
    assign arid    = rd_owner_q ? ID_D : ID_I;
    assign araddr  = rd_addr_q;
    assign arlen   = rd_line_q ? LINE_LEN : 8'd0;
    assign arsize  = 3'd2;
    assign arvalid = resetn && (r_state == R_AR);
    assign rready  = resetn && (r_state == R_DATA);

    // Beats carrying a foreign ID are still acknowledged through rready but
    // are not forwarded to either requester.
    assign beat_match     = rready && rvalid && (rid == arid);
    assign inst_ret_valid = beat_match && !rd_owner_q;
    assign data_ret_valid = beat_match && rd_owner_q;
    assign inst_ret_last  = inst_ret_valid && rlast;
    assign data_ret_last  = data_ret_valid && rlast;
    assign inst_ret_data  = rdata;
    assign data_ret_data  = rdata;

    // Write channels
    assign awid      = ID_D;
    assign awaddr    = wr_addr_q;
    assign awlen     = wr_line_q ? LINE_LEN : 8'd0;
    assign awsize    = 3'd2;
    assign awvalid   = resetn && (w_state == W_AW);
    assign wvalid    = resetn && (w_state == W_W);
    assign wlast_int = (8'(cnt) == awlen);
    assign wlast     = wvalid && wlast_int;
    assign wdata     = wr_words[cnt];
    assign wstrb     = wr_line_q ? 4'hf : wr_strb_q;
    assign bready    = resetn && (w_state == W_B);

    // Read FSM: grant, address phase, then drain beats until rlast.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= R_IDLE;
            rd_addr_q  <= '0;
            rd_line_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (data_grant) begin
                        rd_addr_q  <= data_rd_addr;
                        rd_line_q  <= (data_rd_type == 3'b100);
                        rd_owner_q <= 1'b1;
                        r_state    <= R_AR;
                    end else if (inst_grant) begin
                        rd_addr_q  <= inst_rd_addr;
                        rd_line_q  <= (inst_rd_type == 3'b100);
                        rd_owner_q <= 1'b0;
                        r_state    <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) r_state <= R_DATA;
                end
                R_DATA: begin
                    if (rvalid && rlast) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: capture, address phase, data beats, then wait for response.
    // The beat counter stops at awlen so wdata never indexes past the line.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state   <= W_IDLE;
            wr_addr_q <= '0;
            wr_line_q <= 1'b0;
            wr_strb_q <= '0;
            cnt       <= '0;
            for (int i = 0; i < LINE_WORDS; i++) wr_words[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_req) begin
                        wr_addr_q <= data_wr_addr;
                        wr_line_q <= (data_wr_type == 3'b100);
                        wr_strb_q <= data_wr_wstrb;
                        cnt       <= '0;
                        for (int i = 0; i < LINE_WORDS; i++)
                            wr_words[i] <= data_wr_data[32*i +: 32];
                        w_state   <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) w_state <= W_W;
                end
                W_W: begin
                    if (wready) begin
                        if (wlast_int) w_state <= W_B;
                        else           cnt     <= cnt + 1'b1;
                    end
                end
                W_B: begin
                    if (bvalid) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// tb_axi_bus_arbiter
// Directed testbench for axi_bus_arbiter. Each task drives one scenario and
// compares outputs against hand-computed values. Inputs change on the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_axi_bus_arbiter;

    logic         clk;
    logic         resetn;
    logic         inst_rd_req;
    logic [2:0]   inst_rd_type;
    logic [31:0]  inst_rd_addr;
    logic         inst_rd_rdy;
    logic         inst_ret_valid;
    logic         inst_ret_last;
    logic [31:0]  inst_ret_data;
    logic         data_rd_req;
    logic [2:0]   data_rd_type;
    logic [31:0]  data_rd_addr;
    logic         data_rd_rdy;
    logic         data_ret_valid;
    logic         data_ret_last;
    logic [31:0]  data_ret_data;
    logic         data_wr_req;
    logic [2:0]   data_wr_type;
    logic [31:0]  data_wr_addr;
    logic [3:0]   data_wr_wstrb;
    logic [127:0] data_wr_data;
    logic         data_wr_rdy;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bvalid;
    logic         bready;

    int checks = 0;
    int errors = 0;

    axi_bus_arbiter #(.LINE_WORDS(4), .ID_INST(0), .ID_DATA(1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
        .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
        .inst_ret_data(inst_ret_data),
        .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
        .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
        .data_ret_data(data_ret_data),
        .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
        .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        inst_rd_req = 0; inst_rd_type = 3'b010; inst_rd_addr = '0;
        data_rd_req = 0; data_rd_type = 3'b010; data_rd_addr = '0;
        data_wr_req = 0; data_wr_type = 3'b010; data_wr_addr = '0;
        data_wr_wstrb = '0; data_wr_data = '0;
        arready = 0; rid = '0; rdata = '0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
    endtask

    // Requests are presented during reset; nothing may be accepted or driven.
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        inst_rd_req = 1; data_rd_req = 1; data_rd_addr = 32'h0000_2000; data_wr_req = 1;
        rvalid = 1;
        #1;
        checks++; if (inst_rd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_rdy: got %0b want 0", inst_rd_rdy); end
        checks++; if (data_rd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_rdy: got %0b want 0", data_rd_rdy); end
        checks++; if (data_wr_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_rdy: got %0b want 0", data_wr_rdy); end
        checks++; if ({arvalid, rready, awvalid, wvalid, wlast, bready} !== 6'b0) begin errors++; $display("[TB] FAIL reset_axi_valids: got %b want 000000", {arvalid, rready, awvalid, wvalid, wlast, bready}); end
        checks++; if ({inst_ret_valid, data_ret_valid} !== 2'b0) begin errors++; $display("[TB] FAIL reset_ret_valid: got %b want 00", {inst_ret_valid, data_ret_valid}); end
        checks++; if (arsize !== 3'd2 || awsize !== 3'd2) begin errors++; $display("[TB] FAIL reset_sizes: got ar=%0d aw=%0d want 2", arsize, awsize); end
        @(negedge clk);
        idle_inputs();
        resetn = 1;
        #1;
        checks++; if ({arvalid, awvalid, inst_rd_rdy, data_rd_rdy} !== 4'b0) begin errors++; $display("[TB] FAIL reset_idle_after: got %b want 0000", {arvalid, awvalid, inst_rd_rdy, data_rd_rdy}); end
    endtask

    task automatic test_inst_line_read();
        @(negedge clk);
        inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1fc0_0010;
        #1;
        checks++; if (inst_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL iline_rdy: got %0b want 1", inst_rd_rdy); end
        @(negedge clk);
        inst_rd_req = 0; arready = 1;
        #1;
        checks++; if (inst_rd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL iline_rdy_pulse: got %0b want 0", inst_rd_rdy); end
        checks++; if ({arvalid, arid, arlen, araddr} !== {1'b1, 4'd0, 8'd3, 32'h1fc0_0010}) begin errors++; $display("[TB] FAIL iline_ar: got v=%0b id=%0d len=%0d addr=%h want v=1 id=0 len=3 addr=1fc00010", arvalid, arid, arlen, araddr); end
        @(negedge clk);
        arready = 0;
        #1;
        checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("[TB] FAIL iline_rdata_state: got arvalid=%0b rready=%0b want 0 1", arvalid, rready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rvalid = 1; rid = 4'd0; rdata = 32'h1000_0000 + 32'(i); rlast = (i == 3);
            #1;
            checks++; if ({inst_ret_valid, inst_ret_last, data_ret_valid} !== {1'b1, (i == 3), 1'b0}) begin errors++; $display("[TB] FAIL iline_beat%0d_flags: got v=%0b last=%0b dv=%0b want v=1 last=%0b dv=0", i, inst_ret_valid, inst_ret_last, data_ret_valid, (i == 3)); end
            checks++; if (inst_ret_data !== 32'h1000_0000 + 32'(i)) begin errors++; $display("[TB] FAIL iline_beat%0d_data: got %h want %h", i, inst_ret_data, 32'h1000_0000 + 32'(i)); end
        end
        @(negedge clk);
        rvalid = 0; rlast = 0;
        #1;
        checks++; if (rready !== 1'b0) begin errors++; $display("[TB] FAIL iline_done_rready: got %0b want 0", rready); end
    endtask

    // Data wins a same-cycle contest; inst waits until the cycle after rlast.
    // A beat with a foreign rid is consumed silently.
    task automatic test_priority();
        @(negedge clk);
        inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h1fc0_0000;
        data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_2000;
        #1;
        checks++; if ({data_rd_rdy, inst_rd_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL prio_grant: got data=%0b inst=%0b want 1 0", data_rd_rdy, inst_rd_rdy); end
        @(negedge clk);
        data_rd_req = 0; arready = 1;
        #1;
        checks++; if ({arvalid, arid, arlen, araddr, inst_rd_rdy} !== {1'b1, 4'd1, 8'd0, 32'h0000_2000, 1'b0}) begin errors++; $display("[TB] FAIL prio_data_ar: got v=%0b id=%0d len=%0d addr=%h irdy=%0b want 1 1 0 00002000 0", arvalid, arid, arlen, araddr, inst_rd_rdy); end
        @(negedge clk);
        arready = 0;
        #1;
        checks++; if (inst_rd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL prio_inst_wait: got %0b want 0", inst_rd_rdy); end
        @(negedge clk);
        rvalid = 1; rid = 4'd1; rlast = 1; rdata = 32'h5555_0001;
        #1;
        checks++; if ({data_ret_valid, data_ret_last, inst_ret_valid, inst_rd_rdy} !== 4'b1100) begin errors++; $display("[TB] FAIL prio_data_beat: got dv=%0b dl=%0b iv=%0b irdy=%0b want 1 1 0 0", data_ret_valid, data_ret_last, inst_ret_valid, inst_rd_rdy); end
        checks++; if (data_ret_data !== 32'h5555_0001) begin errors++; $display("[TB] FAIL prio_data_value: got %h want 55550001", data_ret_data); end
        @(negedge clk);
        rvalid = 0; rlast = 0;
        #1;
        checks++; if (inst_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL prio_inst_grant: got %0b want 1", inst_rd_rdy); end
        @(negedge clk);
        inst_rd_req = 0; arready = 1;
        #1;
        checks++; if ({arvalid, arid, arlen} !== {1'b1, 4'd0, 8'd0}) begin errors++; $display("[TB] FAIL prio_inst_ar: got v=%0b id=%0d len=%0d want 1 0 0", arvalid, arid, arlen); end
        @(negedge clk);
        arready = 0;
        rvalid = 1; rid = 4'd1; rlast = 0; rdata = 32'hdead_beef;
        #1;
        checks++; if ({rready, inst_ret_valid, data_ret_valid} !== 3'b100) begin errors++; $display("[TB] FAIL prio_bad_rid: got rready=%0b iv=%0b dv=%0b want 1 0 0", rready, inst_ret_valid, data_ret_valid); end
        @(negedge clk);
        rid = 4'd0; rlast = 1; rdata = 32'h0000_00aa;
        #1;
        checks++; if ({inst_ret_valid, inst_ret_last, inst_ret_data} !== {2'b11, 32'h0000_00aa}) begin errors++; $display("[TB] FAIL prio_inst_beat: got v=%0b l=%0b d=%h want 1 1 000000aa", inst_ret_valid, inst_ret_last, inst_ret_data); end
        @(negedge clk);
        rvalid = 0; rlast = 0;
    endtask

    // Line write with wready stalls, a same-line data read held until after
    // bvalid, and an instruction read that proceeds meanwhile.
    task automatic test_line_write_hazard();
        @(negedge clk);
        data_wr_req = 1; data_wr_type = 3'b100; data_wr_addr = 32'h0000_1230;
        data_wr_data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_1234;
        #1;
        checks++; if ({data_wr_rdy, data_rd_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL hz_accept: got wr=%0b rd=%0b want 1 0", data_wr_rdy, data_rd_rdy); end
        // B: address phase; inst read slips in while data is held
        @(negedge clk);
        data_wr_req = 0; awready = 1;
        inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h1fc0_0100;
        #1;
        checks++; if ({awvalid, awid, awlen, awaddr} !== {1'b1, 4'd1, 8'd3, 32'h0000_1230}) begin errors++; $display("[TB] FAIL hz_aw: got v=%0b id=%0d len=%0d addr=%h want 1 1 3 00001230", awvalid, awid, awlen, awaddr); end
        checks++; if ({data_rd_rdy, inst_rd_rdy} !== 2'b01) begin errors++; $display("[TB] FAIL hz_inst_bypass: got drdy=%0b irdy=%0b want 0 1", data_rd_rdy, inst_rd_rdy); end
        // C: beat A accepted; inst address handshake
        @(negedge clk);
        awready = 0; inst_rd_req = 0; wready = 1; arready = 1;
        #1;
        checks++; if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'hAAAA_AAAA, 4'hf, 1'b0}) begin errors++; $display("[TB] FAIL hz_beatA: got v=%0b d=%h s=%h l=%0b want 1 aaaaaaaa f 0", wvalid, wdata, wstrb, wlast); end
        checks++; if ({arvalid, arid} !== {1'b1, 4'd0}) begin errors++; $display("[TB] FAIL hz_inst_ar: got v=%0b id=%0d want 1 0", arvalid, arid); end
        // D, E: wready low for two cycles on beat B; inst beat arrives on E
        @(negedge clk);
        wready = 0; arready = 0;
        #1;
        checks++; if ({wdata, wlast} !== {32'hBBBB_BBBB, 1'b0}) begin errors++; $display("[TB] FAIL hz_stall1: got d=%h l=%0b want bbbbbbbb 0", wdata, wlast); end
        @(negedge clk);
        rvalid = 1; rid = 4'd0; rlast = 1; rdata = 32'h0bad_f00d;
        #1;
        checks++; if ({wvalid, wdata} !== {1'b1, 32'hBBBB_BBBB}) begin errors++; $display("[TB] FAIL hz_stall2: got v=%0b d=%h want 1 bbbbbbbb", wvalid, wdata); end
        checks++; if ({inst_ret_valid, data_ret_valid} !== 2'b10) begin errors++; $display("[TB] FAIL hz_inst_beat: got iv=%0b dv=%0b want 1 0", inst_ret_valid, data_ret_valid); end
        // F, G, H: beats B, C, D
        @(negedge clk);
        rvalid = 0; rlast = 0; wready = 1;
        #1;
        checks++; if (wdata !== 32'hBBBB_BBBB) begin errors++; $display("[TB] FAIL hz_beatB: got %h want bbbbbbbb", wdata); end
        @(negedge clk);
        #1;
        checks++; if ({wdata, wlast, data_rd_rdy} !== {32'hCCCC_CCCC, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL hz_beatC: got d=%h l=%0b drdy=%0b want cccccccc 0 0", wdata, wlast, data_rd_rdy); end
        @(negedge clk);
        #1;
        checks++; if ({wdata, wlast} !== {32'hDDDD_DDDD, 1'b1}) begin errors++; $display("[TB] FAIL hz_beatD: got d=%h l=%0b want dddddddd 1", wdata, wlast); end
        // I, J: response phase, data read still held
        @(negedge clk);
        wready = 0;
        #1;
        checks++; if ({bready, wvalid, data_rd_rdy} !== 3'b100) begin errors++; $display("[TB] FAIL hz_b_wait: got b=%0b wv=%0b drdy=%0b want 1 0 0", bready, wvalid, data_rd_rdy); end
        @(negedge clk);
        bvalid = 1;
        #1;
        checks++; if ({bready, data_rd_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL hz_b_hs: got b=%0b drdy=%0b want 1 0", bready, data_rd_rdy); end
        // K: write idle, held read released
        @(negedge clk);
        bvalid = 0;
        #1;
        checks++; if ({bready, awvalid, data_rd_rdy} !== 3'b001) begin errors++; $display("[TB] FAIL hz_release: got b=%0b aw=%0b drdy=%0b want 0 0 1", bready, awvalid, data_rd_rdy); end
        @(negedge clk);
        data_rd_req = 0; arready = 1;
        #1;
        checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h0000_1234}) begin errors++; $display("[TB] FAIL hz_data_ar: got v=%0b id=%0d addr=%h want 1 1 00001234", arvalid, arid, araddr); end
        @(negedge clk);
        arready = 0; rvalid = 1; rid = 4'd1; rlast = 1; rdata = 32'h1234_5678;
        #1;
        checks++; if ({data_ret_valid, data_ret_data} !== {1'b1, 32'h1234_5678}) begin errors++; $display("[TB] FAIL hz_data_beat: got v=%0b d=%h want 1 12345678", data_ret_valid, data_ret_data); end
        @(negedge clk);
        rvalid = 0; rlast = 0;
    endtask

    task automatic test_word_write();
        @(negedge clk);
        data_wr_req = 1; data_wr_type = 3'b010; data_wr_addr = 32'h1faf_f002;
        data_wr_wstrb = 4'b0100; data_wr_data = {96'h0, 32'h00ab_0000};
        #1;
        checks++; if (data_wr_rdy !== 1'b1) begin errors++; $display("[TB] FAIL ww_rdy: got %0b want 1", data_wr_rdy); end
        @(negedge clk);
        data_wr_req = 0; awready = 1;
        #1;
        checks++; if ({awvalid, awlen, awaddr} !== {1'b1, 8'd0, 32'h1faf_f002}) begin errors++; $display("[TB] FAIL ww_aw: got v=%0b len=%0d addr=%h want 1 0 1faff002", awvalid, awlen, awaddr); end
        @(negedge clk);
        awready = 0; wready = 1;
        #1;
        checks++; if ({wvalid, wstrb, wlast, wdata} !== {1'b1, 4'b0100, 1'b1, 32'h00ab_0000}) begin errors++; $display("[TB] FAIL ww_beat: got v=%0b s=%b l=%0b d=%h want 1 0100 1 00ab0000", wvalid, wstrb, wlast, wdata); end
        @(negedge clk);
        wready = 0; bvalid = 1;
        #1;
        checks++; if ({bready, wvalid} !== 2'b10) begin errors++; $display("[TB] FAIL ww_b: got b=%0b wv=%0b want 1 0", bready, wvalid); end
        @(negedge clk);
        bvalid = 0;
        #1;
        checks++; if (bready !== 1'b0) begin errors++; $display("[TB] FAIL ww_idle: got %0b want 0", bready); end
    endtask

    // Reset two beats into a line read abandons it; a new request is taken
    // straight after reset is released.
    task automatic test_reset_mid_read();
        @(negedge clk);
        data_rd_req = 1; data_rd_type = 3'b100; data_rd_addr = 32'h0000_4000;
        #1;
        checks++; if (data_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rm_rdy: got %0b want 1", data_rd_rdy); end
        @(negedge clk);
        data_rd_req = 0; arready = 1;
        @(negedge clk);
        arready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rvalid = 1; rid = 4'd1; rlast = 0; rdata = 32'h4000_0000 + 32'(i);
            #1;
            checks++; if (data_ret_valid !== 1'b1) begin errors++; $display("[TB] FAIL rm_beat%0d: got %0b want 1", i, data_ret_valid); end
        end
        @(negedge clk);
        resetn = 0; rvalid = 0;
        @(negedge clk);
        resetn = 1; rvalid = 1; rlast = 1;
        data_rd_req = 1; data_rd_type = 3'b100; data_rd_addr = 32'h0000_5000;
        #1;
        checks++; if ({rready, arvalid, data_ret_valid, inst_ret_valid} !== 4'b0) begin errors++; $display("[TB] FAIL rm_abandon: got rr=%0b ar=%0b dv=%0b iv=%0b want 0 0 0 0", rready, arvalid, data_ret_valid, inst_ret_valid); end
        checks++; if (data_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rm_new_req: got %0b want 1", data_rd_rdy); end
        @(negedge clk);
        data_rd_req = 0; rvalid = 0; rlast = 0;
        #1;
        checks++; if ({arvalid, arid, arlen, araddr} !== {1'b1, 4'd1, 8'd3, 32'h0000_5000}) begin errors++; $display("[TB] FAIL rm_new_ar: got v=%0b id=%0d len=%0d addr=%h want 1 1 3 00005000", arvalid, arid, arlen, araddr); end
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        test_reset();
        test_inst_line_read();
        test_priority();
        test_line_write_hazard();
        test_word_write();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bus_arbiter.md
Name: axi_bus_arbiter

Overview:
- Single-master AXI-style bus interface behind the cache layer. Arbitrates read requests from the instruction side (icache) and the data side (dcache/uncache).
- The data side is already merged by its cache-select mux and presents one rd/wr request set.
- Sequences one read transaction and one write transaction at a time on separate FSMs.
- Holds a data read that hits the line of an in-flight write until the write completes.

Parameters:
- LINE_WORDS, 4, words per cache line; arlen/awlen = LINE_WORDS-1 for line transfers.
- ID_INST, 0, arid used for instruction-side reads.
- ID_DATA, 1, arid/awid used for data-side transfers.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- inst_rd_req  in  1  icache read request.
- inst_rd_type  in  3  3'b010 = single word, 3'b100 = line.
- inst_rd_addr  in  32  physical address.
- inst_rd_rdy  out  1  request accepted this cycle.
- inst_ret_valid  out  1  read beat valid.
- inst_ret_last  out  1  last beat.
- inst_ret_data  out  32  beat data.
- data_rd_req, data_rd_type[3], data_rd_addr[32], data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data[32]: same meanings, data side.
- data_wr_req  in  1  write request.
- data_wr_type  in  3  3'b010 = word, 3'b100 = line.
- data_wr_addr  in  32  address.
- data_wr_wstrb  in  4  byte strobe for word writes.
- data_wr_data  in  32*LINE_WORDS  line data; word writes use [31:0].
- data_wr_rdy  out  1  write accepted this cycle.
- arid[4] out, araddr[32] out, arlen[8] out, arsize[3] out (always 3'd2), arvalid out, arready in.
- rid[4] in, rdata[32] in, rlast in, rvalid in, rready out.
- awid[4] out, awaddr[32] out, awlen[8] out, awsize[3] out (always 3'd2), awvalid out, awready in.
- wdata[32] out, wstrb[4] out, wlast out, wvalid out, wready in.
- bvalid in, bready out.

Behaviour:
- Reset (resetn=0 at a clk edge) forces both FSMs to idle and clears captured address/type/owner and the beat counter.
- While in reset or idle, these outputs are 0: arvalid, rready, awvalid, wvalid, wlast, bready, *_rd_rdy, *_ret_valid, data_wr_rdy.
- Reset mid-transaction abandons the transaction; no completion beat is reported.

Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
- Grant in R_IDLE: the data side has priority over the instruction side.
- Hazard hold: a data read is not eligible while the write FSM is not W_IDLE and data_rd_addr[31:4] == the captured write address [31:4].
- Also hold a data read that is presented in the same cycle as an accepted write to the same line.
- The instruction side may be granted while the data side is held.
- Granted requester's rd_rdy is combinational, high only in the grant cycle. Address, type and owner are captured at that edge, then the FSM moves to R_AR.
- R_AR: arvalid=1, araddr=captured address. arlen=LINE_WORDS-1 for a line read, 0 for a word read. arid = owner ID. On arvalid&&arready go to R_DATA.
- R_DATA: rready=1. Each rvalid beat drives the owner's ret_valid=1, ret_data=rdata, ret_last=rlast in the same cycle; the other side's ret_valid stays 0.
- On rvalid&&rlast return to R_IDLE. The earliest next grant is the following cycle.

Write FSM: W_IDLE -> W_AW -> W_W -> W_B -> W_IDLE.
- W_IDLE: data_wr_req gives data_wr_rdy=1 combinationally. Address, type, strobe and data are captured, and the beat counter is cleared.
- W_AW: awvalid=1, awlen = LINE_WORDS-1 or 0, awid=ID_DATA. On handshake go to W_W.
- W_W: wvalid=1, wdata = word[cnt] of the captured data.
  - wstrb = 4'hf for a line write, captured strobe for a word write.
  - wlast = (cnt == awlen).
  - cnt increments on wvalid&&wready.
  - On the last-beat handshake go to W_B.
- W_B: bready=1. On bvalid go to W_IDLE; this also releases any hazard hold.

Concurrency and widths:
- Read and write FSMs run concurrently and independently.
- The beat counter is 2 bits wide for LINE_WORDS=4 and saturates at awlen.
- A beat with rvalid but a mismatched rid is still acknowledged, but no ret_valid is raised.

Test Plan:
- Inst line read at 0x1fc0_0010: inst_rd_rdy pulses 1 cycle, then arvalid with arid=0, arlen=3; 4 rvalid beats -> inst_ret_valid x4, inst_ret_last on the 4th only, data_ret_valid=0.
- Same-cycle inst and data word reads: data granted first (arid=1, arlen=0). Inst is granted the cycle after data's rlast and inst_rd_rdy stays low until then.
- Line write to 0x0000_1230 with data 0xA..D, wready held low 2 cycles on beat 1: wdata sequence A,B,C,D; wlast only on D; bready until bvalid; then W_IDLE.
- Data read of 0x0000_1234 issued during that write: data_rd_rdy=0 until the cycle after bvalid. A concurrent inst read is granted normally.
- Word write with wstrb=4'b0100 to 0x1faf_f002: awlen=0, one beat with wstrb=4'b0100, wlast=1.
- resetn=0 in R_DATA after 2 beats: next cycle rready=0, arvalid=0, ret_valid=0. A new request is accepted in the first cycle after resetn=1.
